sequenciador_acoes: RTL and testbench

Parametrised action sequencer for the autonomous toy.
- A debounced speed button cycles through a stop level plus NUM_VEL run speeds.
- Each run speed selects a tick period. After TICKS_ACAO ticks the block issues one action pulse and advances a wrapping action counter.
- Sits between the board clock/power inputs and the display/LED drivers. It replaces the fixed 4-speed chaining with a configurable speed count, configurable period, cycle-complete flag and explicit pause.

---
 rtl/pkg_brinquedo.sv | 24 ++
 rtl/debounce_botao.sv | 55 +++++
 rtl/sequenciador_acoes.sv | 98 +++++++++
 tb/tb_sequenciador_acoes.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_brinquedo.sv
// Shared constants and width/period helpers for the toy action sequencer.
package pkg_brinquedo;

  localparam int unsigned VEL_PARADO = 0;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned largura(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned vel_w(input int unsigned num_vel);
    return largura(num_vel + 1);
  endfunction

  function automatic int unsigned acao_w(input int unsigned max_acoes);
    return largura(max_acoes);
  endfunction

  // Clock cycles per tick at a given speed level; the stopped level reports the base.
  function automatic int unsigned periodo(input int unsigned base, input int unsigned vel);
    return (vel == VEL_PARADO) ? base : (base >> (vel - 1));
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Button conditioner: 2-FF synchroniser, stable-level debouncer and a
// one-cycle pulse on each debounced 0->1 transition.
module debounce_botao
  import pkg_brinquedo::*;
#(
  parameter int DEB_CYC = 1000
) (
  input  logic clk_input,
  input  logic reset,
  input  logic clear,
  input  logic botao,
  output logic pressao
);

  localparam int CNT_W = largura(DEB_CYC);

  logic             sync_a;
  logic             sync_b;
  logic             estavel;
  logic [CNT_W-1:0] cnt;
  logic             vira;

  // The level flips on the DEB_CYC-th consecutive differing sample.
  assign vira = (sync_b != estavel) && (cnt == CNT_W'(DEB_CYC - 1));

  always_ff @(posedge clk_input or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values; blocking here would collapse the synchroniser into a single stage.
    if (!reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      estavel <= 1'b0;
      cnt     <= '0;
      pressao <= 1'b0;
    end else if (clear) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      estavel <= 1'b0;
      cnt     <= '0;
      pressao <= 1'b0;
    end else begin
      sync_a  <= botao;
      sync_b  <= sync_a;
      pressao <= vira && !estavel;
      if (sync_b == estavel) begin
        cnt <= '0;
      end else if (vira) begin
        estavel <= ~estavel;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sequenciador_acoes.sv
// Action sequencer: the speed button cycles stop/1..NUM_VEL, each speed sets a
// tick period, and every TICKS_ACAO ticks one action is issued and counted.
module sequenciador_acoes
  import pkg_brinquedo::*;
#(
  parameter int CLK_DIV_BASE = 50000,
  parameter int NUM_VEL      = 3,
  parameter int TICKS_ACAO   = 8,
  parameter int MAX_ACOES    = 9,
  parameter int DEB_CYC      = 1000,
  parameter int VEL_W        = vel_w(NUM_VEL),
  parameter int ACAO_W       = acao_w(MAX_ACOES)
) (
  input  logic              clk_input,
  input  logic              reset,
  input  logic              power,
  input  logic              pausa,
  input  logic              botao_velocidade,
  output logic [VEL_W-1:0]  velocidade,
  output logic              ativo,
  output logic              acao_pulso,
  output logic [ACAO_W-1:0] acao_cont,
  output logic              ciclo_completo
);

  localparam int PRESC_W = largura(CLK_DIV_BASE);
  localparam int TICK_W  = largura(TICKS_ACAO);

  logic               pressao;
  logic               limpa;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_fim;
  logic [TICK_W-1:0]  ticks;
  logic               tick;
  logic               fim_acao;
  logic               volta;
  logic [VEL_W-1:0]   vel_prox;

  assign limpa = ~power;

  debounce_botao #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk_input (clk_input),
    .reset     (reset),
    .clear     (limpa),
    .botao     (botao_velocidade),
    .pressao   (pressao)
  );

  always_comb begin
    // NOTE: every output of this block is given a value before any condition, so no path leaves one unassigned and no latch is inferred.
    ativo     = 1'b0;
    tick      = 1'b0;
    fim_acao  = 1'b0;
    volta     = 1'b0;
    vel_prox  = velocidade + VEL_W'(1);
    presc_fim = PRESC_W'(periodo(CLK_DIV_BASE, 32'(velocidade)) - 1);

    ativo    = power && (velocidade != VEL_W'(VEL_PARADO)) && !pausa;
    tick     = ativo && (presc == presc_fim);
    fim_acao = tick && (ticks == TICK_W'(TICKS_ACAO - 1));
    volta    = acao_cont == ACAO_W'(MAX_ACOES - 1);
    if (velocidade == VEL_W'(NUM_VEL)) vel_prox = VEL_W'(VEL_PARADO);
  end

  always_ff @(posedge clk_input or negedge reset) begin
    if (!reset) begin
      velocidade     <= '0;
      presc          <= '0;
      ticks          <= '0;
      acao_cont      <= '0;
      acao_pulso     <= 1'b0;
      ciclo_completo <= 1'b0;
    end else if (!power) begin
      velocidade     <= '0;
      presc          <= '0;
      ticks          <= '0;
      acao_cont      <= '0;
      acao_pulso     <= 1'b0;
      ciclo_completo <= 1'b0;
    end else if (pressao) begin
      // A press restarts the period, overriding any tick due in this cycle.
      velocidade     <= vel_prox;
      presc          <= '0;
      ticks          <= '0;
      acao_pulso     <= 1'b0;
      ciclo_completo <= 1'b0;
    end else begin
      acao_pulso     <= fim_acao;
      ciclo_completo <= fim_acao && volta;
      if (ativo) presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) ticks <= fim_acao ? '0 : ticks + TICK_W'(1);
      if (fim_acao) acao_cont <= volta ? '0 : acao_cont + ACAO_W'(1);
    end
  end

endmodule

// File: tb/tb_sequenciador_acoes.sv
// Directed bench for sequenciador_acoes: stimulus pushes expected action
// pulses into a queue, a negedge monitor pops and compares them.
module tb_sequenciador_acoes;

  localparam int CLK_DIV_BASE = 8;
  localparam int NUM_VEL      = 3;
  localparam int TICKS_ACAO   = 2;
  localparam int MAX_ACOES    = 3;
  localparam int DEB_CYC      = 4;
  localparam int VEL_W        = 2;
  localparam int ACAO_W       = 2;

  logic              clk_input = 1'b0;
  logic              reset = 1'b1;
  logic              power = 1'b0;
  logic              pausa = 1'b0;
  logic              botao_velocidade = 1'b0;
  logic [VEL_W-1:0]  velocidade;
  logic              ativo;
  logic              acao_pulso;
  logic [ACAO_W-1:0] acao_cont;
  logic              ciclo_completo;

  typedef struct {
    int cyc;
    int cont;
    int ciclo;
  } pulso_t;

  pulso_t esperado[$];
  pulso_t mon_p;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_cont = 0;
  int e1, e2, e3, e4, e5, e6, e7;

  sequenciador_acoes #(
    .CLK_DIV_BASE (CLK_DIV_BASE),
    .NUM_VEL      (NUM_VEL),
    .TICKS_ACAO   (TICKS_ACAO),
    .MAX_ACOES    (MAX_ACOES),
    .DEB_CYC      (DEB_CYC)
  ) dut (
    .clk_input        (clk_input),
    .reset            (reset),
    .power            (power),
    .pausa            (pausa),
    .botao_velocidade (botao_velocidade),
    .velocidade       (velocidade),
    .ativo            (ativo),
    .acao_pulso       (acao_pulso),
    .acao_cont        (acao_cont),
    .ciclo_completo   (ciclo_completo)
  );

  always #5 clk_input = ~clk_input;

  // Edge counter: sampled on a negedge it equals the index of the last rising edge.
  always @(posedge clk_input) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-computed action spacing per speed: TICKS_ACAO * (CLK_DIV_BASE >> (v-1)).
  function automatic int spacing(input int v);
    case (v)
      1:       return 16;
      2:       return 8;
      3:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic push_pulse(input int at);
    pulso_t p;
    exp_cont = (exp_cont + 1) % MAX_ACOES;
    p.cyc   = at;
    p.cont  = exp_cont;
    p.ciclo = (exp_cont == 0) ? 1 : 0;
    esperado.push_back(p);
  endtask

  // Raise the raw button at a negedge for 'hold' edges; speed must change on edge c0+7.
  task automatic press(input int hold, input int prev_vel, input int exp_vel,
                       input int n_pulses, output int e);
    int c0;
    int last;
    c0 = cyc;
    e  = c0 + 7;
    botao_velocidade = 1'b1;
    last = (hold > 7) ? hold : 7;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk_input);
      if (i == hold) botao_velocidade = 1'b0;
      if (i == 6) check("vel_before_change", int'(velocidade), prev_vel);
      if (i == 7) begin
        check("vel_after_change", int'(velocidade), exp_vel);
        for (int k = 1; k <= n_pulses; k++) push_pulse(e + k * spacing(exp_vel));
      end
    end
    repeat (8) @(negedge clk_input);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_input);
  endtask

  always @(negedge clk_input) begin
    if (acao_pulso) begin
      if (esperado.size() == 0) begin
        check("unexpected_pulse", int'(acao_pulso), 0);
      end else begin
        mon_p = esperado.pop_front();
        check("pulse_edge", cyc, mon_p.cyc);
        check("pulse_cont", int'(acao_cont), mon_p.cont);
        check("pulse_ciclo", int'(ciclo_completo), mon_p.ciclo);
      end
    end else if (ciclo_completo) begin
      check("stray_ciclo", int'(ciclo_completo), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    check("rst_vel", int'(velocidade), 0);
    check("rst_ativo", int'(ativo), 0);
    check("rst_cont", int'(acao_cont), 0);
    check("rst_pulso", int'(acao_pulso), 0);
    check("rst_ciclo", int'(ciclo_completo), 0);
    repeat (3) @(negedge clk_input);
    reset = 1'b1;
    power = 1'b1;
    repeat (100) @(negedge clk_input);
    check("idle_vel", int'(velocidade), 0);
    check("idle_ativo", int'(ativo), 0);

    // Bouncy press: never DEB_CYC equal samples in a row
    botao_velocidade = 1'b1; repeat (2) @(negedge clk_input);
    botao_velocidade = 1'b0; repeat (1) @(negedge clk_input);
    botao_velocidade = 1'b1; repeat (2) @(negedge clk_input);
    botao_velocidade = 1'b0; repeat (10) @(negedge clk_input);
    check("bounce_vel", int'(velocidade), 0);

    // Clean press: speed 1, three actions wrapping the counter
    press(10, 0, 1, 3, e1);
    check("spd1_ativo", int'(ativo), 1);
    wait_until(e1 + 52);
    check("spd1_wrap_cont", int'(acao_cont), 0);

    // Press held 6 cycles -> speed 2, spacing 8
    press(6, 1, 2, 2, e2);
    wait_until(e2 + 12);

    // Speed 3, spacing 4; next press lands on speed 0
    press(6, 2, 3, 3, e3);
    press(6, 3, 0, 0, e4);
    repeat (30) @(negedge clk_input);
    check("stop_ativo", int'(ativo), 0);
    check("stop_cont_kept", int'(acao_cont), 2);

    // Pause mid-period at speed 1 shifts the remaining actions by 20 edges
    press(6, 0, 1, 0, e5);
    wait_until(e5 + 10);
    pausa = 1'b1;
    repeat (10) @(negedge clk_input);
    check("pause_ativo", int'(ativo), 0);
    check("pause_cont", int'(acao_cont), 2);
    repeat (10) @(negedge clk_input);
    pausa = 1'b0;
    push_pulse(e5 + 36);
    push_pulse(e5 + 52);

    // Press lands on the edge an action was due: no pulse, speed 2 restarts
    wait_until(e5 + 61);
    press(6, 1, 2, 1, e6);

    // power=0 clears at the next edge
    wait_until(e6 + 12);
    power = 1'b0;
    check("pwr_before_edge_vel", int'(velocidade), 2);
    @(negedge clk_input);
    check("pwr_vel", int'(velocidade), 0);
    check("pwr_cont", int'(acao_cont), 0);
    check("pwr_ativo", int'(ativo), 0);
    exp_cont = 0;
    botao_velocidade = 1'b1;
    repeat (10) @(negedge clk_input);
    botao_velocidade = 1'b0;
    repeat (6) @(negedge clk_input);
    power = 1'b1;
    repeat (10) @(negedge clk_input);
    check("pwr_button_ignored", int'(velocidade), 0);

    // Reset mid-count clears without waiting for an edge
    press(6, 0, 1, 0, e7);
    wait_until(e7 + 12);
    #2 reset = 1'b0;
    #1;
    check("async_rst_vel", int'(velocidade), 0);
    check("async_rst_ativo", int'(ativo), 0);
    repeat (20) @(negedge clk_input);
    reset = 1'b1;
    repeat (10) @(negedge clk_input);
    check("post_rst_vel", int'(velocidade), 0);
    check("queue_drained", esperado.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
